lock_attempt_ctrl: RTL
======================

Name: lock_attempt_ctrl

Overview:
- Supervises the button-sequence unlock detector: edge-detects raw buttons, forwards single-cycle press pulses, and frames each entry attempt as exactly CODE_LEN presses.
- Holds the detector in reset between attempts, times the door-open window, and counts failed attempts.
- Enforces a lockout after repeated failures.
- Sits between the debounced button inputs and the detector; the detector's unlock output feeds back as unlock_in.

Parameters:
- CODE_LEN, 5, presses per attempt (matches detector code length).
- OPEN_CYCLES, 8, cycles door_open is held after a successful unlock.
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout (1..15).
- LOCKOUT_CYCLES, 16, cycles lockout is held.
- TIMEOUT_CYCLES, 32, idle cycles inside an attempt before it is abandoned.

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- button_0  in  1  debounced, synchronous level, "0" key.
- button_1  in  1  debounced, synchronous level, "1" key.
- unlock_in  in  1  unlock flag from the detector.
- det_button_0  out  1  registered one-cycle press pulse to the detector.
- det_button_1  out  1  registered one-cycle press pulse to the detector.
- det_rst_n  out  1  registered active-low reset to the detector.
- door_open  out  1  high while the door is released.
- lockout  out  1  high during the penalty lockout.
- attempt_fail  out  1  one-cycle pulse per failed attempt.
- fail_count  out  4  consecutive failed attempts.

Behaviour:
- Reset (rst=0): state IDLE; det_button_0/1=0, door_open=0, lockout=0, attempt_fail=0, fail_count=0; det_rst_n=0; edge-detect history=0.
- det_rst_n goes to 1 on the first clock edge after reset release.

Press detection:
- pressX = button_X & ~button_X_prev.
- A press in IDLE or ENTRY is forwarded as det_button_X=1 in the next cycle only.
- Both buttons rising in the same cycle: counts as one press, nothing is forwarded, and the attempt's bad flag is set.
- Presses in CHECK, OPEN, RESYNC or LOCKOUT are ignored: not counted, not forwarded.

States:
- IDLE: first press goes to ENTRY with press_cnt=1 and the idle timer cleared.
- ENTRY:
  - Each press increments press_cnt and clears the idle timer.
  - When press_cnt reaches CODE_LEN, go to CHECK.
  - If the idle timer reaches TIMEOUT_CYCLES, go to RESYNC; the attempt is not counted as a failure.
- CHECK: lasts exactly 2 cycles, covering the detector's pulse-to-unlock latency.
  - unlock_in=1 in either cycle with bad=0: go to OPEN.
  - Otherwise: go to FAIL.
- OPEN: door_open=1 for exactly OPEN_CYCLES cycles; fail_count cleared on entry; then go to RESYNC.
- FAIL: single cycle.
  - attempt_fail=1; fail_count increments.
  - If the new count equals MAX_FAIL, go to LOCKOUT; else go to RESYNC.
- LOCKOUT: lockout=1 for exactly LOCKOUT_CYCLES cycles; fail_count cleared on exit; then go to RESYNC.
- RESYNC: single cycle with det_rst_n=0; clears press_cnt and bad; then go to IDLE.

Other rules:
- unlock_in outside CHECK is ignored.
- Reset mid-operation aborts immediately to reset values; no pulses complete.
- Held buttons generate no further presses until released and pressed again.

Test Plan:
- Presses 1,1,0,1,0 (each 1 cycle high, 2 cycles apart), detector model unlocks -> door_open high for exactly 8 cycles starting 1 cycle after the CHECK hit; det_rst_n low 1 cycle after; fail_count=0.
- Presses 1,0,0,0,0 -> no unlock; attempt_fail pulses once; fail_count=1; det_rst_n pulse; next correct code opens the door and clears fail_count to 0.
- Three wrong 5-press attempts -> fail_count 1,2,3; lockout high 16 cycles; presses during lockout produce no det_button pulses; fail_count=0 after lockout.
- Two presses then 32 idle cycles -> RESYNC (det_rst_n low 1 cycle); attempt_fail stays 0; fail_count unchanged.
- Both buttons rising together as 3rd press, correct presses otherwise, unlock_in forced high in CHECK -> treated as fail; attempt_fail=1; door_open stays 0.
- rst asserted mid-ENTRY and mid-OPEN -> all outputs at reset values immediately; det_rst_n=0; normal entry works after release.

Source files
------------

// File: rtl/lock_attempt_ctrl.sv
// Attempt supervisor for the button-sequence unlock detector: forwards press pulses,
// frames CODE_LEN-press attempts, times the door window and enforces failure lockout.
module lock_attempt_ctrl #(
    parameter int CODE_LEN       = 5,
    parameter int OPEN_CYCLES    = 8,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       button_0,
    input  logic       button_1,
    input  logic       unlock_in,
    output logic       det_button_0,
    output logic       det_button_1,
    output logic       det_rst_n,
    output logic       door_open,
    output logic       lockout,
    output logic       attempt_fail,
    output logic [3:0] fail_count
);

    localparam int MAX_HOLD = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_MAX  = (MAX_HOLD > TIMEOUT_CYCLES) ? MAX_HOLD : TIMEOUT_CYCLES;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);
    localparam int CNT_W    = $clog2(CODE_LEN + 1);

    localparam logic [TMR_W-1:0] TMR_OPEN_LAST    = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LOCK_LAST    = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_CHECK_LAST   = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL         = CNT_W'(CODE_LEN);
    localparam logic [3:0]       FAIL_LIMIT       = 4'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_OPEN,
        S_FAIL,
        S_LOCKOUT,
        S_RESYNC
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_btn0_prev;
    logic             r_btn1_prev;
    logic [CNT_W-1:0] r_press_cnt;
    logic [CNT_W-1:0] w_press_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_bad;
    logic             w_bad_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic [3:0]       r_fail_count;
    logic [3:0]       w_fail_count_nxt;
    logic             r_det_b0;
    logic             r_det_b1;
    logic             r_det_rst_n;

    logic             w_press0;
    logic             w_press1;
    logic             w_any_press;
    logic             w_both_press;
    logic             w_accepting;

    assign w_press0     = button_0 & ~r_btn0_prev;
    assign w_press1     = button_1 & ~r_btn1_prev;
    assign w_any_press  = w_press0 | w_press1;
    assign w_both_press = w_press0 & w_press1;
    assign w_accepting  = (r_state == S_IDLE) || (r_state == S_ENTRY);
    assign w_cnt_inc    = r_press_cnt + CNT_W'(1);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_btn0_prev  <= 1'b0;
            r_btn1_prev  <= 1'b0;
            r_press_cnt  <= '0;
            r_bad        <= 1'b0;
            r_timer      <= '0;
            r_fail_count <= 4'd0;
            r_det_b0     <= 1'b0;
            r_det_b1     <= 1'b0;
            r_det_rst_n  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_btn0_prev  <= button_0;
            r_btn1_prev  <= button_1;
            r_press_cnt  <= w_press_cnt_nxt;
            r_bad        <= w_bad_nxt;
            r_timer      <= w_timer_nxt;
            r_fail_count <= w_fail_count_nxt;
            // A simultaneous double press is never forwarded to the detector
            r_det_b0     <= w_accepting & w_press0 & ~w_both_press;
            r_det_b1     <= w_accepting & w_press1 & ~w_both_press;
            r_det_rst_n  <= (w_state_nxt != S_RESYNC);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_press_cnt_nxt  = r_press_cnt;
        w_bad_nxt        = r_bad;
        w_timer_nxt      = r_timer;
        w_fail_count_nxt = r_fail_count;

        case (r_state)
            S_IDLE: begin
                if (w_any_press) begin
                    w_press_cnt_nxt = CNT_W'(1);
                    w_bad_nxt       = w_both_press;
                    w_timer_nxt     = '0;
                    w_state_nxt     = (CNT_W'(1) == CNT_FULL) ? S_CHECK : S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (w_any_press) begin
                    w_press_cnt_nxt = w_cnt_inc;
                    w_bad_nxt       = r_bad | w_both_press;
                    w_timer_nxt     = '0;
                    if (w_cnt_inc == CNT_FULL) begin
                        w_state_nxt = S_CHECK;
                    end
                end else if (r_timer == TMR_TIMEOUT_LAST) begin
                    // Abandoned attempt: resync the detector without a penalty
                    w_state_nxt = S_RESYNC;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            S_CHECK: begin
                // Two cycles cover the detector's pulse-to-unlock latency
                if (unlock_in && !r_bad) begin
                    w_state_nxt      = S_OPEN;
                    w_timer_nxt      = '0;
                    w_fail_count_nxt = 4'd0;
                end else if (r_timer == TMR_CHECK_LAST) begin
                    w_state_nxt      = S_FAIL;
                    w_fail_count_nxt = r_fail_count + 4'd1;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            S_OPEN: begin
                if (r_timer == TMR_OPEN_LAST) begin
                    w_state_nxt = S_RESYNC;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            S_FAIL: begin
                if (r_fail_count == FAIL_LIMIT) begin
                    w_state_nxt = S_LOCKOUT;
                    w_timer_nxt = '0;
                end else begin
                    w_state_nxt = S_RESYNC;
                end
            end
            S_LOCKOUT: begin
                if (r_timer == TMR_LOCK_LAST) begin
                    w_state_nxt      = S_RESYNC;
                    w_fail_count_nxt = 4'd0;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            S_RESYNC: begin
                w_press_cnt_nxt = '0;
                w_bad_nxt       = 1'b0;
                w_timer_nxt     = '0;
                w_state_nxt     = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign det_button_0 = r_det_b0;
    assign det_button_1 = r_det_b1;
    assign det_rst_n    = r_det_rst_n;
    assign door_open    = (r_state == S_OPEN);
    assign lockout      = (r_state == S_LOCKOUT);
    assign attempt_fail = (r_state == S_FAIL);
    assign fail_count   = r_fail_count;

endmodule
